sincos_interp: RTL and testbench



---
 rtl/sincos_interp_if.sv | 34 +++
 rtl/sincos_interp.sv | 191 +++++++++++++++++++
 tb/tb_sincos_interp.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sincos_interp_if.sv
// Bus bundle for sincos_interp: sample request, table port and result strobe.
//   in_valid/in_load/in_phase : request side (phase or frequency/load word)
//   rom_a_cos/rom_a_sin       : quarter-wave table addresses
//   rom_d_cos/rom_d_sin       : {coarse, slope} table words
//   out_valid/out_cos/out_sin : signed quadrature results
// slave = generator side, master = source + table side.
interface sincos_interp_if #(
   parameter int unsigned PW  = 24,
   parameter int unsigned TAB = 10,
   parameter int unsigned CW  = 22,
   parameter int unsigned SW  = 13,
   parameter int unsigned NBO = 23
);
   logic                  in_valid;
   logic                  in_load;
   logic [PW-1:0]         in_phase;
   logic [TAB-1:0]        rom_a_cos;
   logic [TAB-1:0]        rom_a_sin;
   logic [CW+SW-1:0]      rom_d_cos;
   logic [CW+SW-1:0]      rom_d_sin;
   logic                  out_valid;
   logic signed [NBO-1:0] out_cos;
   logic signed [NBO-1:0] out_sin;

   modport slave (
      input  in_valid, in_load, in_phase, rom_d_cos, rom_d_sin,
      output rom_a_cos, rom_a_sin, out_valid, out_cos, out_sin
   );

   modport master (
      output in_valid, in_load, in_phase, rom_d_cos, rom_d_sin,
      input  rom_a_cos, rom_a_sin, out_valid, out_cos, out_sin
   );
endinterface

// File: rtl/sincos_interp.sv
// Quadrature sine/cosine generator: folds the phase into a quarter-wave cosine
// table, linearly interpolates {coarse, slope} entries, rounds, clamps and
// restores the sign. Optional NCO mode turns in_phase into a frequency word.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : sincos_interp_if.slave (request, table port, results)
// Latency is ROM_LAT + 4 cycles, one sample per clock, no stalls.
module sincos_interp #(
   parameter int unsigned PW      = 24,
   parameter int unsigned TAB     = 10,
   parameter int unsigned CW      = 22,
   parameter int unsigned SW      = 13,
   parameter int unsigned NBO     = 23,
   parameter int unsigned ROM_LAT = 2,
   parameter int unsigned MODE    = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   sincos_interp_if.slave bus
);
   localparam int unsigned XW  = PW - 2;          // folded index width
   localparam int unsigned FW  = XW - TAB;        // fine (interpolation) bits
   localparam int unsigned MW  = CW + FW;         // interpolated magnitude width
   localparam int unsigned MW1 = MW + 1;
   localparam int unsigned PRW = SW + FW;         // slope * fine product width
   localparam int unsigned S   = MW - (NBO - 1);  // output scaling shift
   localparam logic [MW:0]     RND  = MW1'(1) << (S - 1);
   localparam logic [NBO-1:0]  MAXV = {1'b0, {(NBO-1){1'b1}}};

   // Round-half-up, clamp to the positive full scale, apply sign.
   function automatic logic signed [NBO-1:0] scale(input logic [MW-1:0] mf,
                                                   input logic          neg);
      logic [MW:0]    sum;
      logic [NBO-1:0] mag;
      sum = MW1'(mf) + RND;
      mag = sum[MW:S];
      if (mag[NBO-1]) mag = MAXV;
      return neg ? -$signed(mag) : $signed(mag);
   endfunction

   // ---------------- phase / accumulator stage ----------------
   logic [PW-1:0] acc;
   logic [PW-1:0] ph_q;
   logic          v_ph;
   logic          take_c;

   // A load cycle in NCO mode swallows the request.
   assign take_c = bus.in_valid && !(MODE == 1 && bus.in_load);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc  <= '0;
         ph_q <= '0;
         v_ph <= 1'b0;
      end else begin
         v_ph <= take_c;
         if (MODE == 1) begin
            if (bus.in_load) begin
               acc <= bus.in_phase;
            end else if (bus.in_valid) begin
               ph_q <= acc;
               acc  <= acc + bus.in_phase;
            end
         end else if (bus.in_valid) begin
            ph_q <= bus.in_phase;
         end
      end
   end

   // ---------------- quadrant fold ----------------
   logic [1:0]    q_c;
   logic [XW-1:0] r_c;
   logic [XW-1:0] x_cos_c;
   logic [XW-1:0] x_sin_c;
   logic          neg_cos_c;
   logic          neg_sin_c;

   always_comb begin
      q_c       = ph_q[PW-1:PW-2];
      r_c       = ph_q[XW-1:0];
      x_cos_c   = q_c[0] ? ~r_c : r_c;
      x_sin_c   = q_c[0] ? r_c : ~r_c;
      neg_cos_c = q_c[1] ^ q_c[0];
      neg_sin_c = q_c[1];
   end

   // ---------------- address stage + table-latency alignment ----------------
   // Index 0 is captured with the address; index ROM_LAT lines up with rom_d.
   logic [FW-1:0]    f_cos_d [ROM_LAT+1];
   logic [FW-1:0]    f_sin_d [ROM_LAT+1];
   logic [ROM_LAT:0] neg_cos_d;
   logic [ROM_LAT:0] neg_sin_d;
   logic [ROM_LAT:0] v_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rom_a_cos <= '0;
         bus.rom_a_sin <= '0;
         neg_cos_d     <= '0;
         neg_sin_d     <= '0;
         v_d           <= '0;
         for (int i = 0; i <= int'(ROM_LAT); i++) begin
            f_cos_d[i] <= '0;
            f_sin_d[i] <= '0;
         end
      end else begin
         bus.rom_a_cos <= x_cos_c[XW-1:FW];
         bus.rom_a_sin <= x_sin_c[XW-1:FW];
         f_cos_d[0]    <= x_cos_c[FW-1:0];
         f_sin_d[0]    <= x_sin_c[FW-1:0];
         neg_cos_d[0]  <= neg_cos_c;
         neg_sin_d[0]  <= neg_sin_c;
         v_d[0]        <= v_ph;
         for (int i = 1; i <= int'(ROM_LAT); i++) begin
            f_cos_d[i]   <= f_cos_d[i-1];
            f_sin_d[i]   <= f_sin_d[i-1];
            neg_cos_d[i] <= neg_cos_d[i-1];
            neg_sin_d[i] <= neg_sin_d[i-1];
            v_d[i]       <= v_d[i-1];
         end
      end
   end

   // ---------------- multiply stage ----------------
   logic [CW-1:0]  crs_cos_q;
   logic [CW-1:0]  crs_sin_q;
   logic [PRW-1:0] prd_cos_q;
   logic [PRW-1:0] prd_sin_q;
   logic           neg_cos_mul;
   logic           neg_sin_mul;
   logic           v_mul;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         crs_cos_q   <= '0;
         crs_sin_q   <= '0;
         prd_cos_q   <= '0;
         prd_sin_q   <= '0;
         neg_cos_mul <= 1'b0;
         neg_sin_mul <= 1'b0;
         v_mul       <= 1'b0;
      end else begin
         crs_cos_q   <= bus.rom_d_cos[CW+SW-1:SW];
         crs_sin_q   <= bus.rom_d_sin[CW+SW-1:SW];
         prd_cos_q   <= PRW'(bus.rom_d_cos[SW-1:0]) * PRW'(f_cos_d[ROM_LAT]);
         prd_sin_q   <= PRW'(bus.rom_d_sin[SW-1:0]) * PRW'(f_sin_d[ROM_LAT]);
         neg_cos_mul <= neg_cos_d[ROM_LAT];
         neg_sin_mul <= neg_sin_d[ROM_LAT];
         v_mul       <= v_d[ROM_LAT];
      end
   end

   // ---------------- subtract stage: coarse*2^FW - slope*f ----------------
   logic [MW-1:0] mf_cos_q;
   logic [MW-1:0] mf_sin_q;
   logic          neg_cos_sub;
   logic          neg_sin_sub;
   logic          v_sub;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mf_cos_q    <= '0;
         mf_sin_q    <= '0;
         neg_cos_sub <= 1'b0;
         neg_sin_sub <= 1'b0;
         v_sub       <= 1'b0;
      end else begin
         mf_cos_q    <= (MW'(crs_cos_q) << FW) - MW'(prd_cos_q);
         mf_sin_q    <= (MW'(crs_sin_q) << FW) - MW'(prd_sin_q);
         neg_cos_sub <= neg_cos_mul;
         neg_sin_sub <= neg_sin_mul;
         v_sub       <= v_mul;
      end
   end

   // ---------------- round / clamp / negate; results hold between strobes ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_cos   <= '0;
         bus.out_sin   <= '0;
      end else begin
         bus.out_valid <= v_sub;
         if (v_sub) begin
            bus.out_cos <= scale(mf_cos_q, neg_cos_sub);
            bus.out_sin <= scale(mf_sin_q, neg_sin_sub);
         end
      end
   end
endmodule

// File: tb/tb_sincos_interp.sv
// Scoreboard bench for sincos_interp: one direct-phase and one NCO instance,
// each fed by a behavioural quarter-wave table with ROM_LAT cycles of latency.
module tb_sincos_interp;
   localparam int unsigned PW      = 24;
   localparam int unsigned TAB     = 10;
   localparam int unsigned CW      = 22;
   localparam int unsigned SW      = 13;
   localparam int unsigned NBO     = 23;
   localparam int unsigned ROM_LAT = 2;
   localparam int          L       = ROM_LAT + 4;
   localparam int          AMP     = 4194303;
   localparam real         PI      = 3.14159265358979323846;

   typedef struct {
      int ec;
      int tc;
      int es;
      int ts;
      int due;
      int tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   tag_cnt = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [PW-1:0] acc_m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sincos_interp_if b0 ();
   sincos_interp_if b1 ();

   sincos_interp #(.PW(PW), .TAB(TAB), .CW(CW), .SW(SW), .NBO(NBO),
                   .ROM_LAT(ROM_LAT), .MODE(0)) u_direct (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b0.slave)
   );

   sincos_interp #(.PW(PW), .TAB(TAB), .CW(CW), .SW(SW), .NBO(NBO),
                   .ROM_LAT(ROM_LAT), .MODE(1)) u_nco (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1.slave)
   );

   // Quarter-wave table: coarse = round(AMP*cos), slope = difference to next.
   int               coarse [TAB == 10 ? 1025 : 1025];
   logic [CW+SW-1:0] rom_word [1024];

   initial begin
      for (int i = 0; i < 1024; i++)
         coarse[i] = $rtoi(real'(AMP) * $cos(PI / 2.0 * real'(i) / 1024.0) + 0.5);
      coarse[1024] = 0;
      for (int i = 0; i < 1024; i++)
         rom_word[i] = {CW'(coarse[i]), SW'(coarse[i] - coarse[i+1])};
   end

   logic [CW+SW-1:0] rp0c [ROM_LAT];
   logic [CW+SW-1:0] rp0s [ROM_LAT];
   logic [CW+SW-1:0] rp1c [ROM_LAT];
   logic [CW+SW-1:0] rp1s [ROM_LAT];

   always @(posedge clk) begin
      rp0c[0] <= rom_word[b0.rom_a_cos];
      rp0s[0] <= rom_word[b0.rom_a_sin];
      rp1c[0] <= rom_word[b1.rom_a_cos];
      rp1s[0] <= rom_word[b1.rom_a_sin];
      for (int k = 1; k < int'(ROM_LAT); k++) begin
         rp0c[k] <= rp0c[k-1];
         rp0s[k] <= rp0s[k-1];
         rp1c[k] <= rp1c[k-1];
         rp1s[k] <= rp1s[k-1];
      end
   end

   assign b0.rom_d_cos = rp0c[ROM_LAT-1];
   assign b0.rom_d_sin = rp0s[ROM_LAT-1];
   assign b1.rom_d_cos = rp1c[ROM_LAT-1];
   assign b1.rom_d_sin = rp1s[ROM_LAT-1];

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference: ideal wave evaluated at the table position the quadrant rules
   // select (the complemented residue lands one phase LSB before the mirror).
   function automatic int ideal(input logic [PW-1:0] p, input bit is_sin);
      logic [1:0]    q;
      logic [PW-3:0] r;
      logic [PW-3:0] x;
      bit            inv;
      bit            neg;
      int            mag;
      q = p[PW-1:PW-2];
      r = p[PW-3:0];
      case (q)
         2'd0:    begin inv = is_sin;  neg = 1'b0;   end
         2'd1:    begin inv = !is_sin; neg = !is_sin; end
         2'd2:    begin inv = is_sin;  neg = 1'b1;   end
         default: begin inv = !is_sin; neg = is_sin;  end
      endcase
      x   = inv ? ~r : r;
      mag = $rtoi(real'(AMP) * $cos(PI / 2.0 * real'(x) / 4194304.0) + 0.5);
      return neg ? -mag : mag;
   endfunction

   task automatic cmp(input string what, input int inst, input int tag,
                      input int act, input int exp, input int tol);
      n_checks++;
      if (iabs(act - exp) > tol) begin
         n_fail++;
         $display("FAIL %s inst%0d sample%0d: got %0d, expected %0d (+/-%0d)",
                  what, inst, tag, act, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int inst, input int ec, input int tc,
                           input int es, input int ts);
      exp_t e;
      e.ec  = ec;
      e.tc  = tc;
      e.es  = es;
      e.ts  = ts;
      e.due = cyc + 1 + L;
      e.tag = tag_cnt;
      tag_cnt++;
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
   endtask

   // Exact quadrant points carry zero tolerance on their full-scale channel.
   task automatic push_phase(input int inst, input logic [PW-1:0] p);
      int c;
      int s;
      c = ideal(p, 1'b0);
      s = ideal(p, 1'b1);
      push_exp(inst, c, (p[PW-3:0] == '0 && iabs(c) == AMP) ? 0 : 2,
                     s, (p[PW-3:0] == '0 && iabs(s) == AMP) ? 0 : 2);
   endtask

   task automatic check_out(input int inst, input int oc, input int os);
      exp_t e;
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
         n_checks++;
         n_fail++;
         $display("FAIL stray output inst%0d cycle %0d: cos %0d sin %0d, none expected",
                  inst, cyc, oc, os);
         return;
      end
      if (inst == 0) e = q0.pop_front();
      else           e = q1.pop_front();
      cmp("latency", inst, e.tag, cyc, e.due, 0);
      cmp("cos", inst, e.tag, oc, e.ec, e.tc);
      cmp("sin", inst, e.tag, os, e.es, e.ts);
   endtask

   // Monitor: pops and compares whenever a result strobe is seen.
   always @(negedge clk) begin
      if (b0.out_valid === 1'b1) check_out(0, int'(b0.out_cos), int'(b0.out_sin));
      if (b1.out_valid === 1'b1) check_out(1, int'(b1.out_cos), int'(b1.out_sin));
   end

   task automatic drain();
      for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) tick();
      cmp("drain q0", 0, -1, q0.size(), 0, 0);
      cmp("drain q1", 1, -1, q1.size(), 0, 0);
   endtask

   task automatic check_zero(input string what, input int inst);
      if (inst == 0) begin
         cmp({what, " out_valid"}, 0, -1, int'(b0.out_valid), 0, 0);
         cmp({what, " out_cos"},   0, -1, int'(b0.out_cos), 0, 0);
         cmp({what, " out_sin"},   0, -1, int'(b0.out_sin), 0, 0);
         cmp({what, " rom_a_cos"}, 0, -1, int'(b0.rom_a_cos), 0, 0);
         cmp({what, " rom_a_sin"}, 0, -1, int'(b0.rom_a_sin), 0, 0);
      end else begin
         cmp({what, " out_valid"}, 1, -1, int'(b1.out_valid), 0, 0);
         cmp({what, " out_cos"},   1, -1, int'(b1.out_cos), 0, 0);
         cmp({what, " out_sin"},   1, -1, int'(b1.out_sin), 0, 0);
         cmp({what, " rom_a_cos"}, 1, -1, int'(b1.rom_a_cos), 0, 0);
         cmp({what, " rom_a_sin"}, 1, -1, int'(b1.rom_a_sin), 0, 0);
      end
   endtask

   initial begin
      logic [PW-1:0] p;
      rst_n       = 1'b0;
      b0.in_valid = 1'b0;
      b0.in_load  = 1'b0;
      b0.in_phase = '0;
      b1.in_valid = 1'b0;
      b1.in_load  = 1'b0;
      b1.in_phase = '0;
      repeat (3) tick();
      check_zero("reset", 0);
      check_zero("reset", 1);
      rst_n = 1'b1;
      tick();

      // Direct mode: single sample at phase 0.
      b0.in_valid = 1'b1;
      b0.in_phase = 24'h000000;
      push_exp(0, AMP, 0, 0, 2);
      tick();
      b0.in_valid = 1'b0;
      repeat (10) tick();

      // Direct mode: quadrant points back to back.
      b0.in_valid = 1'b1;
      b0.in_phase = 24'h400000; push_exp(0, 0, 2, AMP, 0);  tick();
      b0.in_phase = 24'h800000; push_exp(0, -AMP, 0, 0, 2); tick();
      b0.in_phase = 24'hC00000; push_exp(0, 0, 2, -AMP, 0); tick();

      // Direct mode: random back-to-back phases.
      for (int i = 0; i < 4096; i++) begin
         p = PW'($urandom());
         b0.in_phase = p;
         push_phase(0, p);
         tick();
      end
      b0.in_valid = 1'b0;
      drain();

      // NCO: load 0, then a period-16 sweep that wraps the accumulator.
      b1.in_load  = 1'b1;
      b1.in_phase = '0;
      tick();
      acc_m       = '0;
      b1.in_load  = 1'b0;
      b1.in_valid = 1'b1;
      b1.in_phase = 24'h100000;
      for (int k = 0; k < 20; k++) begin
         if (k == 4) push_exp(1, 0, 2, AMP, 0);
         else        push_phase(1, acc_m);
         acc_m = acc_m + 24'h100000;
         tick();
      end

      // NCO: load together with valid issues nothing; next sample uses the load.
      b1.in_load  = 1'b1;
      b1.in_phase = 24'h800000;
      acc_m       = 24'h800000;
      tick();
      b1.in_load  = 1'b0;
      b1.in_phase = 24'h100000;
      push_exp(1, -AMP, 0, 0, 2);
      acc_m = acc_m + 24'h100000;
      tick();
      b1.in_valid = 1'b0;
      drain();

      // NCO: three samples in flight, then a one-cycle reset drops them.
      b1.in_valid = 1'b1;
      b1.in_phase = 24'h100000;
      repeat (3) tick();
      b1.in_valid = 1'b0;
      rst_n       = 1'b0;
      tick();
      rst_n = 1'b1;
      check_zero("mid-reset", 1);
      check_zero("mid-reset", 0);
      repeat (12) tick();
      b1.in_valid = 1'b1;
      b1.in_phase = 24'h100000;
      push_exp(1, AMP, 0, 0, 2);
      tick();
      b1.in_valid = 1'b0;
      drain();
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
